evt_batcher: RTL and testbench

- Downstream consumer of the toggle-based pulse synchronizer; lives entirely in the destination clock domain.
- Takes the synchronizer's single-cycle event pulses and counts them.
- Coalesces pulses that arrive within a hold-off window into one batch.
- Presents each batch to logic via a valid/ready handshake, with a batch count and a sticky overflow flag.

---
 rtl/evt_batcher.sv | 106 ++++++++++
 tb/tb_evt_batcher.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/evt_batcher.sv
// Coalesces single-cycle event pulses into counted batches offered over valid/ready.
// Optional sticky overflow flag is built when EVT_BATCHER_OVF_EN is defined.
module evt_batcher #(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 4
) (
    input  logic             dst_clk,
    input  logic             dst_rst_n,
    input  logic             evt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] ACC_MAX   = '1;
    localparam logic [7:0]       HOLD_INIT = 8'(HOLDOFF);

    typedef enum logic [1:0] {IDLE, ACCUM, OFFER} state_t;

    state_t           state;
    logic [CNT_W-1:0] acc;
    logic [7:0]       timer;
    logic             acc_sat;
    logic [CNT_W-1:0] acc_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic inc);
        if (inc && (a != ACC_MAX))
            return a + CNT_W'(1);
        return a;
    endfunction

    assign acc_sat  = (acc == ACC_MAX);
    assign acc_next = sat_add(acc, evt_in);

    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            timer     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (evt_in) begin
                        state <= ACCUM;
                        acc   <= CNT_W'(1);
                        timer <= HOLD_INIT;
                    end
                end
                ACCUM: begin
                    // An event on the closing edge still belongs to this batch.
                    if (timer == 8'd0 || acc_sat) begin
                        state     <= OFFER;
                        out_count <= acc_next;
                        acc       <= '0;
                        out_valid <= 1'b1;
                    end else begin
                        acc   <= acc_next;
                        timer <= timer - 8'd1;
                    end
                end
                OFFER: begin
                    // Events arriving while offered build the shadow batch.
                    acc <= acc_next;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (acc_next != '0) begin
                            state <= ACCUM;
                            timer <= HOLD_INIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef EVT_BATCHER_OVF_EN
    logic evt_lost;
    assign evt_lost = evt_in && acc_sat;

    // A loss in the same cycle as a clear keeps the flag set.
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n)
            ovf <= 1'b0;
        else if (evt_lost)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_evt_batcher.sv
// Directed scoreboard bench for evt_batcher: batches are queued as expected and
// popped by a monitor on every handshake.
module tb_evt_batcher;

    localparam int CNT_W   = 8;
    localparam int HOLDOFF = 4;
`ifdef EVT_BATCHER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             evt_in    = 1'b0;
    logic             out_ready = 1'b0;
    logic             ovf_clr   = 1'b0;
    logic             out_valid;
    logic             ovf;
    logic [CNT_W-1:0] out_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int t0;

    typedef struct {
        int count;
        int cyc;
    } exp_t;
    exp_t sb[$];

    evt_batcher #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
        .dst_clk   (clk),
        .dst_rst_n (rst_n),
        .evt_in    (evt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, let one rising edge sample them, then settle.
    task automatic step(input logic e, input logic r);
        evt_in    = e;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int count, input int at_cyc);
        exp_t e;
        e.count = count;
        e.cyc   = at_cyc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_batch: got count %0d expected no batch", out_count);
            end else begin
                e = sb.pop_front();
                chk("batch_count", 32'(out_count), e.count);
                if (e.cyc >= 0)
                    chk("batch_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(out_count), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_n = 1'b1;
        step(0, 1);

        // Isolated pulse
        t0 = cyc;
        push(1, t0 + HOLDOFF + 2);
        step(1, 1);
        repeat (10) step(0, 1);
        chk("t1_idle_valid", 32'(out_valid), 0);
        chk("t1_ovf", 32'(ovf), 0);
        chk("t1_drained", sb.size(), 0);

        // Pulses at 0, 1, 3 coalesce
        t0 = cyc;
        push(3, t0 + HOLDOFF + 2);
        step(1, 1); step(1, 1); step(0, 1); step(1, 1);
        repeat (10) step(0, 1);
        chk("t2_drained", sb.size(), 0);

        // Shadow batch built while the consumer stalls
        t0 = cyc;
        push(1, t0 + 20);
        push(10, t0 + 26);
        for (int i = 0; i <= 32; i++)
            step(i == 0 || (i >= 6 && i <= 15), i >= 20);
        chk("t3_drained", sb.size(), 0);
        chk("t3_idle_valid", 32'(out_valid), 0);

        // Event on the handshake edge joins the next batch
        t0 = cyc;
        push(1, t0 + 7);
        push(1, t0 + 13);
        for (int i = 0; i <= 20; i++)
            step(i == 0 || i == 7, i >= 7);
        chk("t6_drained", sb.size(), 0);

        // Saturation and overflow
        t0 = cyc;
        push(6, -1);
        for (int i = 0; i < 300; i++) begin
            step(1, 0);
            if (i == 260) chk("t4_ovf_before_loss", 32'(ovf), 0);
            if (i == 261) chk("t4_ovf_first_loss", 32'(ovf), 32'(OVF_ON));
        end
        repeat (3) step(0, 0);
        chk("t4_ovf_sticky", 32'(ovf), 32'(OVF_ON));
        chk("t4_offer_valid", 32'(out_valid), 1);
        chk("t4_offer_frozen", 32'(out_count), 6);
        ovf_clr = 1'b1;
        step(1, 0);
        ovf_clr = 1'b0;
        chk("t4_set_beats_clr", 32'(ovf), 32'(OVF_ON));
        ovf_clr = 1'b1;
        step(0, 0);
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", 32'(ovf), 0);
        push(255, -1);
        repeat (6) step(0, 1);
        chk("t4_drained", sb.size(), 0);
        chk("t4_idle_valid", 32'(out_valid), 0);

        // Asynchronous reset while offering
        step(1, 0);
        repeat (7) step(0, 0);
        chk("t5_offer_valid", 32'(out_valid), 1);
        chk("t5_offer_count", 32'(out_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 0);
        chk("t5_async_count", 32'(out_count), 0);
        chk("t5_async_ovf", 32'(ovf), 0);
        @(posedge clk); @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1);
        t0 = cyc;
        push(1, t0 + HOLDOFF + 2);
        step(1, 1);
        repeat (10) step(0, 1);
        chk("t5_idle_valid", 32'(out_valid), 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
